// File: rtl/led_dimmer_ctrl.sv
// Duty-cycle sequencer for the 16-step LED PWM: manual up/down stepping from
// debounced button pulses, or a prescaled breathe ramp 0->15, hold, 15->0, hold.
module led_dimmer_ctrl #(
    parameter int STEP_DIV   = 1000000,
    parameter int DIV_W      = 20,
    parameter int HOLD_STEPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] duty_cycle,
    output logic [2:0] state,
    output logic       step
);

    typedef enum logic [2:0] {
        MANUAL  = 3'd0,
        RAMP_UP = 3'd1,
        HOLD_HI = 3'd2,
        RAMP_DN = 3'd3,
        HOLD_LO = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_STEPS - 1);

    // Kept as a plain vector so codes 5-7 are representable and recoverable.
    logic [2:0]       state_r;
    state_t           state_nx;
    logic [3:0]       duty_r;
    logic [3:0]       duty_nx;
    logic [DIV_W-1:0] pre_r;
    logic [DIV_W-1:0] pre_nx;
    logic [7:0]       hold_r;
    logic [7:0]       hold_nx;
    logic             in_breathe;
    logic             tick;

    function automatic logic [3:0] sat_inc(input logic [3:0] d);
        return (d == 4'd15) ? d : d + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] d);
        return (d == 4'd0) ? d : d - 4'd1;
    endfunction

    assign in_breathe = (state_r >= RAMP_UP) && (state_r <= HOLD_LO);
    assign tick       = in_breathe && (pre_r == DIV_LAST);

    assign step       = tick;
    assign duty_cycle = duty_r;
    assign state      = state_r;

    always_comb begin
        state_nx = MANUAL;
        duty_nx  = duty_r;
        pre_nx   = '0;
        hold_nx  = '0;

        // Prescaler and hold counter only survive while breathe mode is held.
        if (in_breathe && mode) begin
            pre_nx  = tick ? '0 : pre_r + DIV_W'(1);
            hold_nx = hold_r;
        end

        case (state_r)
            MANUAL: begin
                if (mode) begin
                    state_nx = RAMP_UP;
                end else if (inc && !dec) begin
                    duty_nx = sat_inc(duty_r);
                end else if (dec && !inc) begin
                    duty_nx = sat_dec(duty_r);
                end
            end

            RAMP_UP: begin
                if (mode) begin
                    state_nx = RAMP_UP;
                    if (tick) begin
                        if (duty_r == 4'd15) begin
                            state_nx = HOLD_HI;
                            hold_nx  = '0;
                        end else begin
                            duty_nx = sat_inc(duty_r);
                        end
                    end
                end
            end

            HOLD_HI: begin
                if (mode) begin
                    state_nx = HOLD_HI;
                    if (tick) begin
                        if (hold_r == HOLD_LAST) begin
                            state_nx = RAMP_DN;
                            hold_nx  = '0;
                        end else begin
                            hold_nx = hold_r + 8'd1;
                        end
                    end
                end
            end

            RAMP_DN: begin
                if (mode) begin
                    state_nx = RAMP_DN;
                    if (tick) begin
                        if (duty_r == 4'd0) begin
                            state_nx = HOLD_LO;
                            hold_nx  = '0;
                        end else begin
                            duty_nx = sat_dec(duty_r);
                        end
                    end
                end
            end

            HOLD_LO: begin
                if (mode) begin
                    state_nx = HOLD_LO;
                    if (tick) begin
                        if (hold_r == HOLD_LAST) begin
                            state_nx = RAMP_UP;
                            hold_nx  = '0;
                        end else begin
                            hold_nx = hold_r + 8'd1;
                        end
                    end
                end
            end

            default: begin
                state_nx = MANUAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= MANUAL;
            duty_r  <= '0;
            pre_r   <= '0;
            hold_r  <= '0;
        end else begin
            state_r <= state_nx;
            duty_r  <= duty_nx;
            pre_r   <= pre_nx;
            hold_r  <= hold_nx;
        end
    end

endmodule

// File: tb/tb_led_dimmer_ctrl.sv
// Bench for led_dimmer_ctrl: directed test-plan steps followed by random traffic,
// all compared every cycle against an integer reference model of the dimmer.
module tb_led_dimmer_ctrl;

    localparam int SD   = 4;
    localparam int HS   = 2;
    localparam int DIVW = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       inc;
    logic       dec;
    logic [3:0] duty_cycle;
    logic [2:0] state;
    logic       step;

    int checks = 0;
    int errors = 0;

    int m_state, m_duty, m_pre, m_hold;
    int nsteps;
    int found;

    led_dimmer_ctrl #(.STEP_DIV(SD), .DIV_W(DIVW), .HOLD_STEPS(HS)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .inc        (inc),
        .dec        (dec),
        .duty_cycle (duty_cycle),
        .state      (state),
        .step       (step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_step_now();
        return (m_state >= 1 && m_state <= 4 && m_pre == SD - 1) ? 1 : 0;
    endfunction

    // Reference: next-cycle behaviour derived from the dimmer's rules using integers.
    task automatic model_advance(input logic m, input logic i, input logic d, input logic r);
        int tk;
        tk = model_step_now();
        if (r) begin
            m_state = 0; m_duty = 0; m_pre = 0; m_hold = 0;
        end else if (m_state == 0) begin
            if (m) m_state = 1;
            else if (i && !d && m_duty < 15) m_duty++;
            else if (d && !i && m_duty > 0) m_duty--;
        end else if (m_state > 4 || !m) begin
            m_state = 0; m_pre = 0; m_hold = 0;
        end else begin
            m_pre = (m_pre + 1) % SD;
            if (tk == 1) begin
                if (m_state == 1) begin
                    if (m_duty == 15) begin m_state = 2; m_hold = 0; end
                    else m_duty++;
                end else if (m_state == 3) begin
                    if (m_duty == 0) begin m_state = 4; m_hold = 0; end
                    else m_duty--;
                end else begin
                    if (m_hold == HS - 1) begin
                        m_state = (m_state == 2) ? 3 : 1;
                        m_hold  = 0;
                    end else begin
                        m_hold++;
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic m, input logic i, input logic d, input logic r);
        mode  = m;
        inc   = i;
        dec   = d;
        reset = r;
        chk("step", {31'd0, step}, model_step_now());
        if (step === 1'b1) nsteps++;
        model_advance(m, i, d, r);
        @(posedge clk);
        #1;
        chk("duty", {28'd0, duty_cycle}, m_duty);
        chk("state", {29'd0, state}, m_state);
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; inc = 1'b0; dec = 1'b0;
        m_state = 0; m_duty = 0; m_pre = 0; m_hold = 0;
        nsteps = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_duty", {28'd0, duty_cycle}, 0);
        chk("reset_state", {29'd0, state}, 0);
        chk("reset_step", {31'd0, step}, 0);

        // Manual stepping and saturation
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 0, 0);
            chk("inc_pulse", {28'd0, duty_cycle}, k);
            drive(0, 0, 0, 0);
        end
        for (int k = 0; k < 20; k++) drive(0, 1, 0, 0);
        chk("inc_sat", {28'd0, duty_cycle}, 15);
        for (int k = 0; k < 16; k++) drive(0, 0, 1, 0);
        chk("dec_to_zero", {28'd0, duty_cycle}, 0);
        drive(0, 0, 1, 0);
        chk("dec_sat", {28'd0, duty_cycle}, 0);

        // Simultaneous inc/dec, and inc ignored once breathe is selected
        for (int k = 0; k < 5; k++) drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        chk("inc_dec_both", {28'd0, duty_cycle}, 5);
        drive(1, 1, 0, 0);
        chk("enter_breathe_state", {29'd0, state}, 1);
        chk("enter_breathe_duty", {28'd0, duty_cycle}, 5);
        drive(1, 1, 0, 0);
        drive(1, 0, 1, 0);
        chk("inc_ignored_breathe", {28'd0, duty_cycle}, 5);
        drive(0, 0, 0, 0);
        chk("back_manual", {29'd0, state}, 0);

        // Full breathe period from duty 0
        for (int k = 0; k < 5; k++) drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        chk("ramp_entry", {29'd0, state}, 1);
        nsteps = 0;
        for (int n = 1; n <= 144; n++) begin
            drive(1, 0, 0, 0);
            if (n == 3)   chk("no_early_step", {28'd0, duty_cycle}, 0);
            if (n == 4)   chk("tick1_duty", {28'd0, duty_cycle}, 1);
            if (n == 60)  chk("tick15_duty", {28'd0, duty_cycle}, 15);
            if (n == 64)  chk("hold_hi_entry", {29'd0, state}, 2);
            if (n == 72)  chk("ramp_dn_entry", {29'd0, state}, 3);
            if (n == 76)  chk("ramp_dn_first", {28'd0, duty_cycle}, 14);
            if (n == 132) chk("ramp_dn_zero", {28'd0, duty_cycle}, 0);
            if (n == 136) chk("hold_lo_entry", {29'd0, state}, 4);
            if (n == 140) chk("hold_lo_mid", {29'd0, state}, 4);
        end
        chk("period_state", {29'd0, state}, 1);
        chk("period_duty", {28'd0, duty_cycle}, 0);
        chk("period_steps", nsteps, 36);

        // Drop mode on a tick in RAMP_DN at duty 9
        found = 0;
        for (int n = 0; n < 500 && found == 0; n++) begin
            if (m_state == 3 && m_duty == 9 && m_pre == SD - 1) found = 1;
            else drive(1, 0, 0, 0);
        end
        chk("reach_dn9", found, 1);
        chk("exit_step", {31'd0, step}, 1);
        drive(0, 0, 0, 0);
        chk("exit_state", {29'd0, state}, 0);
        chk("exit_duty", {28'd0, duty_cycle}, 9);
        chk("exit_step_after", {31'd0, step}, 0);

        // Reset mid-ramp, then a reset glitch between edges
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 0);
        chk("ramp7_duty", {28'd0, duty_cycle}, 7);
        drive(1, 0, 0, 1);
        chk("rst_duty", {28'd0, duty_cycle}, 0);
        chk("rst_state", {29'd0, state}, 0);
        chk("rst_step", {31'd0, step}, 0);
        for (int k = 0; k < 9; k++) drive(1, 0, 0, 0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        drive(1, 0, 0, 0);
        chk("glitch_duty", {28'd0, duty_cycle}, 2);
        chk("glitch_state", {29'd0, state}, 1);

        // Unused state code recovers to MANUAL
        drive(0, 0, 0, 0);
        force dut.state_r = 3'd6;
        #1;
        chk("forced_state", {29'd0, state}, 6);
        release dut.state_r;
        m_state = 6;
        drive(0, 0, 0, 0);
        chk("illegal_recover", {29'd0, state}, 0);
        chk("illegal_duty", {28'd0, duty_cycle}, 2);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic rm, ri, rd, rr;
            rm = ($urandom_range(0, 39) == 0) ? ~mode : mode;
            ri = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 199) == 0);
            drive(rm, ri, rd, rr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
